// File: rtl/frame_sram.sv
// frame_sram: single-port byte-writable frame store, read latency 1 or 2.
// Define FRAME_SRAM_CLEAR_EN to build in the zero-fill clear sequencer.
module frame_sram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  input  logic                clr,
  output logic                busy
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_rd;
  logic              acc_wr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  assign acc_rd = en & ~we & ~busy;
  assign acc_wr = en & we & ~busy;

`ifdef FRAME_SRAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // the sequencer owns the write port for the whole sweep
  assign busy    = busy_q;
  assign wr_en   = busy_q | acc_wr;
  assign wr_addr = busy_q ? cnt : addr;
  assign wr_data = busy_q ? '0 : data_in;
  assign wr_be   = busy_q ? '1 : be;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign busy       = 1'b0;
  assign wr_en      = acc_wr;
  assign wr_addr    = addr;
  assign wr_data    = data_in;
  assign wr_be      = be;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_W-1:0] rd_q;
  logic              rd_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v <= 1'b0;
      rd_q <= '0;
    end else begin
      rd_v <= acc_rd;
      if (acc_rd) begin
        rd_q <= mem[addr];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] q2;
    logic              v2;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        q2 <= '0;
      end else begin
        v2 <= rd_v;
        if (rd_v) begin
          q2 <= rd_q;
        end
      end
    end

    assign data_out = q2;
    assign rd_valid = v2;
  end else begin : g_lat1
    assign data_out = rd_q;
    assign rd_valid = rd_v;
  end

endmodule

// File: tb/tb_frame_sram.sv
// tb_frame_sram: scoreboard bench, random traffic vs. array reference model.
// Clear-sequencer checks follow FRAME_SRAM_CLEAR_EN.
`timescale 1ns/1ps
module tb_frame_sram;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic          clr = 1'b0;
  logic [NB-1:0] be = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          busy;

  frame_sram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .rd_valid(rd_valid), .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   t;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic          rst_seen = 1'b0;
  logic          started = 1'b0;
  logic [DW-1:0] last = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: reset state, in-order read data, latency, hold between pulses
  exp_t e;
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset data_out", data_out, '0);
      chk("reset rd_valid", DW'(rd_valid), '0);
      last    = '0;
      started = 1'b1;
    end else if (started) begin
      if (rd_valid) begin
        if (q.size() == 0) begin
          chk("spurious rd_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("read data", data_out, e.d);
          chk("read latency", cyc, e.t);
        end
        last = data_out;
      end else begin
        chk("hold data_out", data_out, last);
      end
    end
  end

  // one access slot; model updated with the spec's byte-enable rule
  task automatic op(bit e_, bit w_, logic [NB-1:0] b_,
                    logic [AW-1:0] a_, logic [DW-1:0] d_);
    en = e_; we = w_; be = b_; addr = a_; data_in = d_;
    if (e_) begin
      if (w_) begin
        for (int i = 0; i < NB; i++)
          if (b_[i]) ref_mem[a_][8*i +: 8] = d_[8*i +: 8];
      end else begin
        q.push_back('{ref_mem[a_], cyc + LAT});
      end
    end
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) op(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, '1, AW'(a), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  // counts busy cycles; at iteration poke_at a write to addr 0 and a clr
  // pulse are driven, both of which must be ignored
  task automatic count_busy(input int poke_at, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (i == poke_at) begin
        en = 1'b1; we = 1'b1; be = '1; addr = '0;
        data_in = 32'hDEAD_BEEF; clr = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; we = 1'b0; clr = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    @(posedge clk); #1;
    do_reset();
`ifdef FRAME_SRAM_CLEAR_EN
    count_busy(10, n);
    chk("busy cycles after reset", n, 16);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    read_all();
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b1, '1, AW'(a), $urandom);
    do_reset();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(-1, n);
    chk("busy cycles after restart", n, 16);
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b1, '1, AW'(a), $urandom);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(5, n);
    chk("busy cycles after clr", n, 16);
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    read_all();
`else
    count_busy(3, n);
    chk("busy after reset", n, 0);
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b1, '1, AW'(a), $urandom);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(-1, n);
    chk("busy after clr", n, 0);
    read_all();
`endif
    op(1'b1, 1'b1, 4'hF, 4'h0, 32'hA5A5_1234);
    op(1'b1, 1'b0, 4'hF, 4'h0, '0);
    op(1'b1, 1'b1, 4'hF, 4'h7, 32'h1122_3344);
    op(1'b1, 1'b1, 4'b0101, 4'h7, 32'hFFFF_FFFF);
    op(1'b1, 1'b0, 4'hF, 4'h7, '0);
    op(1'b1, 1'b1, 4'b0000, 4'h7, 32'h0BAD_0BAD);
    op(1'b1, 1'b0, 4'hF, 4'h7, '0);
    op(1'b1, 1'b0, 4'hF, 4'h1, '0);
    op(1'b1, 1'b0, 4'hF, 4'h2, '0);
    op(1'b1, 1'b0, 4'hF, 4'h3, '0);
    op(1'b1, 1'b1, 4'hF, 4'h5, 32'h5555_AAAA);
    op(1'b1, 1'b0, 4'hF, 4'h1, '0);
    idle(3);
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 2))
        0: op(1'b1, 1'b0, '0, AW'($urandom), '0);
        1: op(1'b1, 1'b1, NB'($urandom), AW'($urandom), $urandom);
        default: op(1'b0, 1'b0, '0, '0, '0);
      endcase
    end
    idle(LAT + 3);
    chk("reads outstanding", q.size(), 0);
    en = 1'b1; we = 1'b0; addr = 4'h4;
    @(posedge clk); #1;
    en = 1'b0;
    do_reset();
    idle(4);
`ifdef FRAME_SRAM_CLEAR_EN
    count_busy(-1, n);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
